// File: rtl/pla_vector_sequencer.sv
// pla_vector_sequencer
//   Drives input vectors into an 8-in/18-out combinational PLA and collects its
//   responses. Vectors come from an internal 0..255 sweep (mode=0) or from an
//   external valid/ready stream (mode=1). Each issued vector is registered onto
//   pla_x, the response on pla_z is captured one cycle later, and the
//   {vector, response, last} pair is buffered in a small FIFO that drains on a
//   valid/ready output port. Every delivered response is folded into a rotating
//   XOR signature.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   start, mode                 begin a run (IDLE/DONE only); source select
//   s_valid/s_ready/s_data/s_last   input vector stream
//   pla_x / pla_z               registered PLA input / PLA response
//   m_valid/m_ready/m_vec/m_resp/m_last   output pair stream
//   m_parity                    ^{m_vec, m_resp} (only with PLA_SEQ_PARITY_EN)
//   busy, done                  run in progress / run finished
//   signature                   running response signature
//
// Configuration
//   PLA_SEQ_PARITY_EN  adds the m_parity port and one parity bit per FIFO entry.
module pla_vector_sequencer #(
  parameter int IN_W       = 8,
  parameter int OUT_W      = 18,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IN_W-1:0]  s_data,
  input  logic             s_last,
  output logic [IN_W-1:0]  pla_x,
  input  logic [OUT_W-1:0] pla_z,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [IN_W-1:0]  m_vec,
  output logic [OUT_W-1:0] m_resp,
  output logic             m_last,
`ifdef PLA_SEQ_PARITY_EN
  output logic             m_parity,
`endif
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] signature
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW+1:0] DEPTH_C = (AW+2)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;

  logic              mode_q;
  logic [IN_W-1:0]   sweep_cnt;
  logic              vld_p1;
  logic              last_p1;
  logic [AW:0]       cnt_q, cnt_d;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [IN_W-1:0]   mem_vec  [FIFO_DEPTH];
  logic [OUT_W-1:0]  mem_resp [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_last;
`ifdef PLA_SEQ_PARITY_EN
  logic [FIFO_DEPTH-1:0] mem_par;
`endif

  logic          start_ok, run, push, pop, room;
  logic          sweep_issue, issue, issue_last;
  logic [AW+1:0] occ;

  assign start_ok = start & ((state_q == S_IDLE) | (state_q == S_DONE));
  assign run      = (state_q == S_RUN);
  assign push     = vld_p1;
  assign m_valid  = (cnt_q != '0);
  assign pop      = m_valid & m_ready;

  // Entries already stored plus the one still in flight must leave a capture
  // slot free. A pop on this edge frees one, which keeps 1 pair/cycle flowing.
  assign occ  = {1'b0, cnt_q} + {{(AW+1){1'b0}}, vld_p1};
  assign room = (occ < DEPTH_C) | pop;

  assign s_ready     = run & mode_q & room;
  assign sweep_issue = run & ~mode_q & room;
  assign issue       = sweep_issue | (s_valid & s_ready);
  assign issue_last  = mode_q ? s_last : (sweep_cnt == '1);

  assign cnt_d = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  assign m_vec    = mem_vec[rd_ptr];
  assign m_resp   = mem_resp[rd_ptr];
  assign m_last   = mem_last[rd_ptr];
`ifdef PLA_SEQ_PARITY_EN
  assign m_parity = mem_par[rd_ptr];
`endif
  assign busy = (state_q == S_RUN) | (state_q == S_DRAIN);
  assign done = (state_q == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_RUN;
      S_RUN:          if (issue && issue_last) state_d = S_DRAIN;
      // Nothing issues in DRAIN, so an empty FIFO after this edge means
      // nothing is left in flight either.
      S_DRAIN:        if (cnt_d == '0) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Stage p0: issue a vector onto pla_x
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= 1'b0;
      sweep_cnt <= '0;
      pla_x     <= '0;
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
    end else begin
      vld_p1 <= issue;
      if (start_ok) begin
        mode_q    <= mode;
        sweep_cnt <= '0;
      end else if (sweep_issue) begin
        sweep_cnt <= sweep_cnt + 1'b1;
      end
      if (issue) begin
        pla_x   <= mode_q ? s_data : sweep_cnt;
        last_p1 <= issue_last;
      end
    end
  end

  // Stage p1: capture the settled PLA response into the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mem_last <= '0;
`ifdef PLA_SEQ_PARITY_EN
      mem_par  <= '0;
`endif
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_vec[i]  <= '0;
        mem_resp[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      if (push) begin
        mem_vec[wr_ptr]  <= pla_x;
        mem_resp[wr_ptr] <= pla_z;
        mem_last[wr_ptr] <= last_p1;
`ifdef PLA_SEQ_PARITY_EN
        mem_par[wr_ptr]  <= ^{pla_x, pla_z};
`endif
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Stage p2: output beat folds the response into the signature
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        signature <= '0;
    else if (start_ok) signature <= '0;
    else if (pop)      signature <= {signature[OUT_W-2:0], signature[OUT_W-1]} ^ m_resp;
  end

endmodule

// File: tb/tb_pla_vector_sequencer.sv
module tb_pla_vector_sequencer;

  localparam int IW = 8;
  localparam int OW = 18;

  logic          clk, rst_n, start, mode, s_valid, s_ready, s_last;
  logic [IW-1:0] s_data, pla_x, m_vec;
  logic [OW-1:0] pla_z, m_resp, signature;
  logic          m_valid, m_ready, m_last, busy, done;
`ifdef PLA_SEQ_PARITY_EN
  logic          m_parity;
`endif
  logic          stub_one;

  int checks = 0;
  int errors = 0;

  logic [IW-1:0] q_vec  [$];
  logic [OW-1:0] q_resp [$];
  logic          q_last [$];
  logic [OW-1:0] sig_m;

  pla_vector_sequencer #(.IN_W(IW), .OUT_W(OW), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .pla_x(pla_x), .pla_z(pla_z),
    .m_valid(m_valid), .m_ready(m_ready), .m_vec(m_vec), .m_resp(m_resp), .m_last(m_last),
`ifdef PLA_SEQ_PARITY_EN
    .m_parity(m_parity),
`endif
    .busy(busy), .done(done), .signature(signature)
  );

  // PLA stub
  assign pla_z = stub_one ? OW'(1) : {{(OW-IW){1'b0}}, pla_x};

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic clear_sb();
    q_vec.delete(); q_resp.delete(); q_last.delete();
    sig_m = '0;
  endtask

  task automatic pulse_start(input logic md);
    start = 1'b1; mode = md;
    @(posedge clk); #1;
    start = 1'b0; mode = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({pla_x, s_ready, m_valid, m_vec, m_resp, m_last, busy, done, signature} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: pla_x=%h s_ready=%b m_valid=%b sig=%h busy=%b done=%b, required all 0",
               pla_x, s_ready, m_valid, signature, busy, done);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, m_valid, s_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_idle: busy/done/m_valid/s_ready=%b required 0000", {busy, done, m_valid, s_ready});
    end
  endtask

  task automatic test_sweep();
    logic [IW-1:0] ev; logic [OW-1:0] er; logic el;
    clear_sb();
    stub_one = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      q_vec.push_back(IW'(i)); q_resp.push_back(OW'(i)); q_last.push_back(i == 255);
    end
    pulse_start(1'b0);
    @(negedge clk);
    checks++;
    if ({m_valid, busy, s_ready} !== 3'b010) begin
      errors++;
      $display("FAIL sweep_lat0: m_valid/busy/s_ready=%b required 010", {m_valid, busy, s_ready});
    end
    @(negedge clk);
    checks++;
    if ({m_valid, pla_x} !== {1'b0, 8'h00}) begin
      errors++;
      $display("FAIL sweep_lat1: m_valid=%b pla_x=%h required 0/00", m_valid, pla_x);
    end
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      ev = q_vec.pop_front(); er = q_resp.pop_front(); el = q_last.pop_front();
      checks++;
      if ({m_valid, m_vec, m_resp, m_last} !== {1'b1, ev, er, el}) begin
        errors++;
        $display("FAIL sweep_beat%0d: valid=%b vec=%h resp=%h last=%b required 1/%h/%h/%b",
                 i, m_valid, m_vec, m_resp, m_last, ev, er, el);
      end
      sig_m = {sig_m[OW-2:0], sig_m[OW-1]} ^ er;
      @(negedge clk);
    end
    checks++;
    if ({done, busy, m_valid} !== 3'b100) begin
      errors++;
      $display("FAIL sweep_done: done/busy/m_valid=%b required 100", {done, busy, m_valid});
    end
    checks++;
    if (signature !== sig_m) begin
      errors++;
      $display("FAIL sweep_signature: got %h required %h", signature, sig_m);
    end
  endtask

  task automatic test_stream();
    logic [IW-1:0] vecs [3];
    int got;
    vecs[0] = 8'h3C; vecs[1] = 8'hA5; vecs[2] = 8'h01;
    clear_sb();
    stub_one = 1'b1; m_ready = 1'b1;
    pulse_start(1'b1);
    got = 0;
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          logic hs;
          s_valid = 1'b1; s_data = vecs[k]; s_last = (k == 2);
          q_vec.push_back(vecs[k]); q_resp.push_back(OW'(1)); q_last.push_back(k == 2);
          hs = 1'b0;
          for (int c = 0; c < 50 && !hs; c++) begin
            @(negedge clk); hs = s_ready;
            @(posedge clk); #1;
          end
          checks++;
          if (!hs) begin
            errors++;
            $display("FAIL stream_accept%0d: s_ready=0 required 1 within 50 cycles", k);
          end
        end
        s_valid = 1'b0; s_last = 1'b0; s_data = '0;
      end
      begin
        for (int c = 0; c < 80 && got < 3; c++) begin
          @(negedge clk);
          if (m_valid && m_ready) begin
            checks++;
            if (q_vec.size() == 0) begin
              errors++;
              $display("FAIL stream_extra: unexpected beat vec=%h required none", m_vec);
            end else begin
              logic [IW-1:0] ev; logic [OW-1:0] er; logic el;
              ev = q_vec.pop_front(); er = q_resp.pop_front(); el = q_last.pop_front();
              if ({m_vec, m_resp, m_last} !== {ev, er, el}) begin
                errors++;
                $display("FAIL stream_beat%0d: vec=%h resp=%h last=%b required %h/%h/%b",
                         got, m_vec, m_resp, m_last, ev, er, el);
              end
            end
            got++;
          end
        end
      end
    join
    checks++;
    if (got != 3) begin
      errors++;
      $display("FAIL stream_count: got %0d beats required 3", got);
    end
    for (int c = 0; c < 20 && !done; c++) @(negedge clk);
    checks++;
    if ({done, signature} !== {1'b1, 18'h00007}) begin
      errors++;
      $display("FAIL stream_signature: done=%b sig=%h required 1/00007", done, signature);
    end
  endtask

  task automatic test_backpressure();
    int got;
    clear_sb();
    stub_one = 1'b0; m_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin
      q_vec.push_back(IW'(i)); q_resp.push_back(OW'(i)); q_last.push_back(i == 255);
    end
    pulse_start(1'b0);
    repeat (20) @(negedge clk);
    checks++;
    if ({m_valid, m_vec, pla_x} !== {1'b1, 8'h00, 8'h01}) begin
      errors++;
      $display("FAIL bp_hold: m_valid=%b m_vec=%h pla_x=%h required 1/00/01", m_valid, m_vec, pla_x);
    end
    m_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 400 && got < 256; c++) begin
      if (m_valid) begin
        logic [IW-1:0] ev; logic [OW-1:0] er; logic el;
        ev = q_vec.pop_front(); er = q_resp.pop_front(); el = q_last.pop_front();
        checks++;
        if ({m_vec, m_resp, m_last} !== {ev, er, el}) begin
          errors++;
          $display("FAIL bp_beat%0d: vec=%h resp=%h last=%b required %h/%h/%b",
                   got, m_vec, m_resp, m_last, ev, er, el);
        end
        sig_m = {sig_m[OW-2:0], sig_m[OW-1]} ^ er;
        got++;
      end
      @(negedge clk);
    end
    for (int c = 0; c < 10 && !done; c++) @(negedge clk);
    checks++;
    if ({got == 256, done, m_valid, signature} !== {1'b1, 1'b1, 1'b0, sig_m}) begin
      errors++;
      $display("FAIL bp_end: beats=%0d done=%b m_valid=%b sig=%h required 256/1/0/%h",
               got, done, m_valid, signature, sig_m);
    end
  endtask

  task automatic test_start_during_run();
    int got;
    clear_sb();
    stub_one = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      q_vec.push_back(IW'(i)); q_resp.push_back(OW'(i)); q_last.push_back(i == 255);
    end
    pulse_start(1'b0);
    got = 0;
    for (int c = 0; c < 400 && got < 256; c++) begin
      @(negedge clk);
      start = (got == 10); mode = (got == 10);
      if (m_valid) begin
        logic [IW-1:0] ev; logic [OW-1:0] er; logic el;
        ev = q_vec.pop_front(); er = q_resp.pop_front(); el = q_last.pop_front();
        checks++;
        if ({m_vec, m_resp, m_last, s_ready} !== {ev, er, el, 1'b0}) begin
          errors++;
          $display("FAIL restart_beat%0d: vec=%h resp=%h last=%b s_ready=%b required %h/%h/%b/0",
                   got, m_vec, m_resp, m_last, s_ready, ev, er, el);
        end
        sig_m = {sig_m[OW-2:0], sig_m[OW-1]} ^ er;
        got++;
      end
    end
    start = 1'b0; mode = 1'b0;
    for (int c = 0; c < 10 && !done; c++) @(negedge clk);
    checks++;
    if ({got == 256, done, signature} !== {1'b1, 1'b1, sig_m}) begin
      errors++;
      $display("FAIL restart_end: beats=%0d done=%b sig=%h required 256/1/%h", got, done, signature, sig_m);
    end
  endtask

  task automatic test_reset_midrun();
    logic hit;
    clear_sb();
    stub_one = 1'b0; m_ready = 1'b1;
    pulse_start(1'b0);
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk); hit = (pla_x == 8'h40);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL midrun_reach: pla_x=%h required 40 within 200 cycles", pla_x);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pla_x, s_ready, m_valid, m_vec, m_resp, m_last, busy, done, signature} !== '0) begin
      errors++;
      $display("FAIL midrun_reset: pla_x=%h m_valid=%b m_vec=%h busy=%b sig=%h required all 0",
               pla_x, m_valid, m_vec, busy, signature);
    end
    @(posedge clk); #1;
    checks++;
    if ({m_valid, busy, pla_x} !== '0) begin
      errors++;
      $display("FAIL midrun_hold: m_valid=%b busy=%b pla_x=%h required 0/0/00", m_valid, busy, pla_x);
    end
    rst_n = 1'b1;
  endtask

`ifdef PLA_SEQ_PARITY_EN
  task automatic test_parity();
    logic hs;
    clear_sb();
    stub_one = 1'b1; m_ready = 1'b0;
    pulse_start(1'b1);
    s_valid = 1'b1; s_data = 8'h03; s_last = 1'b1;
    hs = 1'b0;
    for (int c = 0; c < 50 && !hs; c++) begin
      @(negedge clk); hs = s_ready;
      @(posedge clk); #1;
    end
    s_valid = 1'b0; s_last = 1'b0;
    for (int c = 0; c < 20 && !m_valid; c++) @(negedge clk);
    checks++;
    if ({m_valid, m_vec, m_parity} !== {1'b1, 8'h03, 1'b1}) begin
      errors++;
      $display("FAIL parity: m_valid=%b m_vec=%h m_parity=%b required 1/03/1", m_valid, m_vec, m_parity);
    end
    m_ready = 1'b1;
    for (int c = 0; c < 20 && !done; c++) @(negedge clk);
  endtask
`endif

  initial begin
    clk = 1'b0; rst_n = 1'b0; start = 1'b0; mode = 1'b0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0; stub_one = 1'b0;
    sig_m = '0;
    test_reset();
    test_sweep();
    test_stream();
    test_backpressure();
    test_start_during_run();
    test_reset_midrun();
    test_sweep();
`ifdef PLA_SEQ_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
